writeback_queue: RTL and testbench

Buffers completed instruction results from the execution lanes and drives them onto the register file write ports, up to SUPER_SCALAR_WIDTH writes per cycle. It sits between the functional-unit completion outputs and `register_file`, and owns the write side of the register file interface. Results are applied in program order. A per-register pending mask lets issue logic detect writes still in flight.

---
 rtl/writeback_queue.sv | 152 +++++++++++++++
 tb/tb_writeback_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Shared processor types, followed by the writeback queue that buffers lane results in order
// and drives them onto the register file write ports.
package processor_help;
  localparam int unsigned SUPER_SCALAR_WIDTH = 2;
  localparam int unsigned REGISTER_FILE_SIZE = 32;

  typedef logic [31:0] Word;

  typedef struct packed {
    logic                                  write_enable;
    logic [$clog2(REGISTER_FILE_SIZE)-1:0] write_register;
    Word                                   write_data;
  } RegisterFileWriteRequest;
endpackage

module writeback_queue
  import processor_help::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                                                        clk_in,
  input  logic                                                        rst_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                               result_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][$clog2(REGISTER_FILE_SIZE)-1:0] result_reg_in,
  input  Word  [SUPER_SCALAR_WIDTH-1:0]                               result_data_in,
  output logic                                                        result_ready_out,
  input  logic                                                        stall_in,
  output RegisterFileWriteRequest [SUPER_SCALAR_WIDTH-1:0]            write_ports_reg_request_out,
  output logic [REGISTER_FILE_SIZE-1:0]                               pending_mask_out,
  output logic [$clog2(DEPTH):0]                                      count_out
);

  localparam int unsigned W  = SUPER_SCALAR_WIDTH;
  localparam int unsigned RW = $clog2(REGISTER_FILE_SIZE);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [RW-1:0] reg_idx_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  reg_idx_t                    r_mem_reg  [DEPTH];
  Word                         r_mem_data [DEPTH];
  ptr_t                        r_head;
  ptr_t                        r_tail;
  cnt_t                        r_count;
  RegisterFileWriteRequest [W-1:0] r_out;

  logic                        w_ready;
  logic                        w_push;
  cnt_t                        w_push_cnt;
  cnt_t                        w_enq_cnt;
  cnt_t                        w_pop_cnt;
  ptr_t                        w_slot   [W];
  ptr_t                        w_rd_idx [W];
  ptr_t                        w_age    [DEPTH];
  RegisterFileWriteRequest [W-1:0] w_out;
  logic [REGISTER_FILE_SIZE-1:0] w_pending;

  // Ready looks only at the current occupancy, never at a same-edge pop.
  always_comb begin
    w_ready = (cnt_t'(DEPTH) - r_count) >= cnt_t'(W);
  end

  // Valid lanes are packed into consecutive slots starting at the tail.
  always_comb begin
    w_push     = w_ready && (|result_valid_in);
    w_push_cnt = '0;
    for (int i = 0; i < W; i++) begin
      w_slot[i] = r_tail + ptr_t'(w_push_cnt);
      if (result_valid_in[i]) begin
        w_push_cnt = w_push_cnt + cnt_t'(1);
      end
    end
    w_enq_cnt = w_push ? w_push_cnt : '0;
  end

  always_comb begin
    w_out = '0;
    if (stall_in) begin
      w_pop_cnt = '0;
    end else if (r_count < cnt_t'(W)) begin
      w_pop_cnt = r_count;
    end else begin
      w_pop_cnt = cnt_t'(W);
    end
    for (int i = 0; i < W; i++) begin
      w_rd_idx[i] = r_head + ptr_t'(i);
    end
    for (int i = 0; i < W; i++) begin
      if (cnt_t'(i) < w_pop_cnt) begin
        w_out[i].write_register = r_mem_reg[w_rd_idx[i]];
        w_out[i].write_data     = r_mem_data[w_rd_idx[i]];
        w_out[i].write_enable   = (r_mem_reg[w_rd_idx[i]] != '0);
        // An older write shadowed by a younger one in the same group is dropped.
        for (int j = i + 1; j < W; j++) begin
          if ((cnt_t'(j) < w_pop_cnt) && (r_mem_reg[w_rd_idx[j]] == r_mem_reg[w_rd_idx[i]])) begin
            w_out[i].write_enable = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_age[k] = ptr_t'(k) - r_head;
      if (cnt_t'(w_age[k]) < r_count) begin
        w_pending[r_mem_reg[k]] = 1'b1;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (r_out[i].write_enable) begin
        w_pending[r_out[i].write_register] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_out   <= '0;
    end else begin
      r_head  <= r_head + ptr_t'(w_pop_cnt);
      r_tail  <= r_tail + ptr_t'(w_enq_cnt);
      r_count <= r_count + w_enq_cnt - w_pop_cnt;
      r_out   <= w_out;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      for (int i = 0; i < W; i++) begin
        if (result_valid_in[i]) begin
          r_mem_reg[w_slot[i]]  <= result_reg_in[i];
          r_mem_data[w_slot[i]] <= result_data_in[i];
        end
      end
    end
  end

  assign result_ready_out            = w_ready;
  assign write_ports_reg_request_out = r_out;
  assign pending_mask_out            = w_pending;
  assign count_out                   = r_count;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (width 2, depth 8) with a small register file model
// fed by the write ports.
module tb_writeback_queue;
  import processor_help::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [1:0]           result_valid_in;
  logic [1:0][4:0]      result_reg_in;
  Word  [1:0]           result_data_in;
  logic                 result_ready_out;
  logic                 stall_in;
  RegisterFileWriteRequest [1:0] write_ports_reg_request_out;
  logic [31:0]          pending_mask_out;
  logic [3:0]           count_out;

  int n_cmp = 0;
  int n_bad = 0;
  Word rf [32] = '{default: 32'h0};

  writeback_queue #(.DEPTH(8)) dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .result_valid_in             (result_valid_in),
    .result_reg_in               (result_reg_in),
    .result_data_in              (result_data_in),
    .result_ready_out            (result_ready_out),
    .stall_in                    (stall_in),
    .write_ports_reg_request_out (write_ports_reg_request_out),
    .pending_mask_out            (pending_mask_out),
    .count_out                   (count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    for (int l = 0; l < 2; l++) begin
      if (write_ports_reg_request_out[l].write_enable) begin
        rf[write_ports_reg_request_out[l].write_register] <= write_ports_reg_request_out[l].write_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int l, input logic we, input logic [4:0] r,
                          input Word d);
    chk({tag, "_we"},   64'(write_ports_reg_request_out[l].write_enable),   64'(we));
    chk({tag, "_reg"},  64'(write_ports_reg_request_out[l].write_register), 64'(r));
    chk({tag, "_data"}, 64'(write_ports_reg_request_out[l].write_data),     64'(d));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] r0, input Word d0,
                       input logic [4:0] r1, input Word d1);
    result_valid_in  = v;
    result_reg_in[0] = r0;
    result_data_in[0] = d0;
    result_reg_in[1] = r1;
    result_data_in[1] = d1;
  endtask

  initial begin
    rst_in   = 1'b0;
    stall_in = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Reset values
    #2;
    chk("rst_ready", 64'(result_ready_out), 64'd1);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_pending", 64'(pending_mask_out), 64'd0);
    chk_lane("rst_l0", 0, 1'b0, 5'd0, 32'h0);
    chk_lane("rst_l1", 1, 1'b0, 5'd0, 32'h0);
    #9;
    rst_in = 1'b1;

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_ready", 64'(result_ready_out), 64'd1);
    end
    chk("idle_count", 64'(count_out), 64'd0);
    chk("idle_we0", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);

    // Single result on lane 1 only
    drive(2'b10, 5'd0, 32'h0, 5'd5, 32'hDEADBEEF);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("one_count_e", 64'(count_out), 64'd1);
    chk("one_pend_e", 64'(pending_mask_out), 64'h20);
    chk("one_we_e", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);
    tick();
    chk_lane("one_l0", 0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("one_l1_we", 64'(write_ports_reg_request_out[1].write_enable), 64'd0);
    chk("one_count_e1", 64'(count_out), 64'd0);
    chk("one_pend_e1", 64'(pending_mask_out), 64'h20);
    tick();
    chk("one_we_e2", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);
    chk("one_pend_e2", 64'(pending_mask_out), 64'h0);
    chk("one_rf5", 64'(rf[5]), 64'hDEADBEEF);

    // Same-register collapse
    drive(2'b11, 5'd3, 32'd1, 5'd3, 32'd2);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("col_count", 64'(count_out), 64'd2);
    chk("col_pend", 64'(pending_mask_out), 64'h8);
    tick();
    chk_lane("col_l0", 0, 1'b0, 5'd3, 32'd1);
    chk_lane("col_l1", 1, 1'b1, 5'd3, 32'd2);
    chk("col_pend_out", 64'(pending_mask_out), 64'h8);
    tick();
    chk("col_rf3", 64'(rf[3]), 64'd2);
    chk("col_we_after", 64'(write_ports_reg_request_out[1].write_enable), 64'd0);

    // Write to r0
    drive(2'b01, 5'd0, 32'd7, 5'd0, 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("r0_count", 64'(count_out), 64'd1);
    chk("r0_pend_q", 64'(pending_mask_out), 64'h0);
    tick();
    chk_lane("r0_l0", 0, 1'b0, 5'd0, 32'd7);
    chk("r0_pend_out", 64'(pending_mask_out), 64'h0);

    // Fill under stall; head and tail now sit at 4, so the fill wraps
    stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 5'(10 + 2 * k), Word'(100 + 2 * k), 5'(11 + 2 * k), Word'(101 + 2 * k));
      chk("fill_ready", 64'(result_ready_out), 64'd1);
      tick();
      chk("fill_count", 64'(count_out), 64'(2 * k + 2));
      chk("fill_we", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);
    end
    chk("full_ready", 64'(result_ready_out), 64'd0);
    chk("full_pend", 64'(pending_mask_out), 64'h3FC00);
    drive(2'b11, 5'd30, 32'hBAD, 5'd31, 32'hBAD);
    tick();
    chk("full_hold_count", 64'(count_out), 64'd8);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    stall_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_lane("drain_l0", 0, 1'b1, 5'(10 + 2 * k), Word'(100 + 2 * k));
      chk_lane("drain_l1", 1, 1'b1, 5'(11 + 2 * k), Word'(101 + 2 * k));
      chk("drain_count", 64'(count_out), 64'(6 - 2 * k));
    end
    tick();
    chk("empty_we0", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);
    chk("empty_we1", 64'(write_ports_reg_request_out[1].write_enable), 64'd0);
    chk("empty_count", 64'(count_out), 64'd0);
    chk("empty_rf17", 64'(rf[17]), 64'd107);

    // Reset mid-operation with count 5 and staged outputs
    stall_in = 1'b1;
    drive(2'b11, 5'd20, 32'd200, 5'd21, 32'd201);
    tick();
    drive(2'b11, 5'd22, 32'd202, 5'd23, 32'd203);
    tick();
    drive(2'b01, 5'd24, 32'd204, 5'd0, 32'h0);
    tick();
    chk("pre_count5", 64'(count_out), 64'd5);
    stall_in = 1'b0;
    drive(2'b11, 5'd25, 32'd205, 5'd26, 32'd206);
    chk("pre_ready5", 64'(result_ready_out), 64'd1);
    tick();
    chk("pre_count", 64'(count_out), 64'd5);
    chk_lane("pre_l0", 0, 1'b1, 5'd20, 32'd200);
    chk_lane("pre_l1", 1, 1'b1, 5'd21, 32'd201);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_count", 64'(count_out), 64'd0);
    chk("arst_pend", 64'(pending_mask_out), 64'h0);
    chk("arst_ready", 64'(result_ready_out), 64'd1);
    chk_lane("arst_l0", 0, 1'b0, 5'd0, 32'h0);
    chk_lane("arst_l1", 1, 1'b0, 5'd0, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rst_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_we0", 64'(write_ports_reg_request_out[0].write_enable), 64'd0);
      chk("post_we1", 64'(write_ports_reg_request_out[1].write_enable), 64'd0);
      chk("post_count", 64'(count_out), 64'd0);
    end
    chk("post_rf20", 64'(rf[20]), 64'd0);
    chk("post_rf21", 64'(rf[21]), 64'd0);
    chk("post_rf3", 64'(rf[3]), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
